// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO and EX stall request.
// Optional `MDU_EARLY_EXIT_EN: multiplies finish once the remaining multiplier bits are zero.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             StartIn,
  input  logic [1:0]       OpIn,
  input  logic [WIDTH-1:0] DataAIn,
  input  logic [WIDTH-1:0] DataBIn,
  input  logic             ReadHiLoIn,
  input  logic             CancelIn,
  output logic             BusyOut,
  output logic             StallOut,
  output logic             DoneOut,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // state | meaning
  // IDLE  | waiting for an op, HI/LO stable
  // RUN   | one shift-add / restoring-divide step per cycle
  // FIX   | sign fixup, HI/LO write, DoneOut pulse
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state;
  logic [CW-1:0]       count;
  logic                is_div;
  logic                sign_p;
  logic                sign_r;
  logic                b_zero;
  logic [WIDTH-1:0]    a_raw;
  logic [2*WIDTH-1:0]  mcand;
  logic [2*WIDTH-1:0]  acc;
  logic [WIDTH-1:0]    mplier;
  logic [WIDTH-1:0]    divisor;
  logic [WIDTH-1:0]    quo;
  logic [WIDTH-1:0]    rem;

  logic                is_signed;
  logic                neg_a;
  logic                neg_b;
  logic [WIDTH-1:0]    abs_a;
  logic [WIDTH-1:0]    abs_b;
  logic [2*WIDTH-1:0]  acc_nx;
  logic [WIDTH:0]      div_shift;
  logic                div_fits;
  logic [WIDTH-1:0]    div_sub;
  logic [2*WIDTH-1:0]  prod_fix;
  logic [WIDTH-1:0]    quo_fix;
  logic [WIDTH-1:0]    rem_fix;
  logic                early_exit;
  logic                run_last;

  assign is_signed = ~OpIn[0];
  assign neg_a     = is_signed & DataAIn[WIDTH-1];
  assign neg_b     = is_signed & DataBIn[WIDTH-1];
  assign abs_a     = neg_a ? -DataAIn : DataAIn;
  assign abs_b     = neg_b ? -DataBIn : DataBIn;

  assign acc_nx    = mplier[0] ? acc + mcand : acc;

  // The true difference is below the divisor, so a WIDTH-bit subtract is exact.
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_fits  = div_shift >= {1'b0, divisor};
  assign div_sub   = div_shift[WIDTH-1:0] - divisor;

  assign prod_fix  = sign_p ? -acc : acc;
  assign quo_fix   = sign_p ? -quo : quo;
  assign rem_fix   = sign_r ? -rem : rem;

`ifdef MDU_EARLY_EXIT_EN
  assign early_exit = ~is_div & (mplier[WIDTH-1:1] == '0);
`else
  assign early_exit = 1'b0;
`endif

  assign run_last = (count == LAST) | early_exit;

  assign StallOut = BusyOut & (ReadHiLoIn | StartIn);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      count   <= '0;
      is_div  <= 1'b0;
      sign_p  <= 1'b0;
      sign_r  <= 1'b0;
      b_zero  <= 1'b0;
      a_raw   <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      divisor <= '0;
      quo     <= '0;
      rem     <= '0;
      BusyOut <= 1'b0;
      DoneOut <= 1'b0;
      HiOut   <= '0;
      LoOut   <= '0;
    end else begin
      DoneOut <= 1'b0;
      case (state)
        IDLE: begin
          if (StartIn && !CancelIn) begin
            is_div  <= OpIn[1];
            sign_p  <= neg_a ^ neg_b;
            sign_r  <= neg_a;
            b_zero  <= (DataBIn == '0);
            a_raw   <= DataAIn;
            mcand   <= {{WIDTH{1'b0}}, abs_a};
            acc     <= '0;
            mplier  <= abs_b;
            divisor <= abs_b;
            quo     <= abs_a;
            rem     <= '0;
            count   <= '0;
            BusyOut <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (CancelIn) begin
            BusyOut <= 1'b0;
            state   <= IDLE;
          end else begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= div_fits ? div_sub : div_shift[WIDTH-1:0];
            quo    <= {quo[WIDTH-2:0], div_fits};
            count  <= count + CW'(1);
            if (run_last) state <= FIX;
          end
        end
        FIX: begin
          BusyOut <= 1'b0;
          state   <= IDLE;
          if (!CancelIn) begin
            DoneOut <= 1'b1;
            if (!is_div) begin
              HiOut <= prod_fix[2*WIDTH-1:WIDTH];
              LoOut <= prod_fix[WIDTH-1:0];
            end else if (b_zero) begin
              HiOut <= a_raw;
              LoOut <= '1;
            end else begin
              HiOut <= rem_fix;
              LoOut <= quo_fix;
            end
          end
        end
        default: begin
          BusyOut <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized self-checking bench for mdu_sequencer against an arithmetic reference model.
// Honours `MDU_EARLY_EXIT_EN in the expected multiply latency.
module tb_mdu_sequencer;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b1;
  logic         StartIn = 1'b0;
  logic [1:0]   OpIn = 2'd0;
  logic [W-1:0] DataAIn = '0;
  logic [W-1:0] DataBIn = '0;
  logic         ReadHiLoIn = 1'b0;
  logic         CancelIn = 1'b0;
  logic         BusyOut;
  logic         StallOut;
  logic         DoneOut;
  logic [W-1:0] HiOut;
  logic [W-1:0] LoOut;

  int           n_checks = 0;
  int           n_pass = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  mdu_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .StartIn(StartIn), .OpIn(OpIn),
    .DataAIn(DataAIn), .DataBIn(DataBIn), .ReadHiLoIn(ReadHiLoIn),
    .CancelIn(CancelIn), .BusyOut(BusyOut), .StallOut(StallOut),
    .DoneOut(DoneOut), .HiOut(HiOut), .LoOut(LoOut)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference result and RUN length derived from the arithmetic definition of each op.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output int runc);
    longint       sa, sb;
    logic [63:0]  p;
    logic [W-1:0] mag;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      2'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'd2: begin
        if (b == '0) begin lo = '1; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = '0; end
        else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
      default: begin
        if (b == '0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
    runc = W;
`ifdef MDU_EARLY_EXIT_EN
    if (!op[1]) begin
      mag = (op == 2'd0 && b[W-1]) ? -b : b;
      runc = 1;
      while (mag > 1) begin mag = mag >> 1; runc++; end
    end
`endif
    mag = '0;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'($urandom_range(1, 20));
      2: return 32'h0 - 32'($urandom_range(1, 20));
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic logic rd(input int mode);
    if (mode == 2) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  // Called just after a negedge with the DUT idle; returns in the Done cycle if hold, else one cycle later.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int read_mode, input bit hold,
                        input logic [1:0] nop, input logic [W-1:0] na, input logic [W-1:0] nb,
                        input string tag);
    logic [W-1:0] eh, el;
    int runc, got_k, bad;
    model(op, a, b, eh, el, runc);
    StartIn = 1'b1; OpIn = op; DataAIn = a; DataBIn = b; CancelIn = 1'b0;
    ReadHiLoIn = rd(read_mode);
    got_k = -1;
    bad = 0;
    @(negedge Clk);
    for (int k = 0; k < runc + 20; k++) begin
      StartIn = hold;
      if (hold) begin OpIn = nop; DataAIn = na; DataBIn = nb; end
      ReadHiLoIn = rd(read_mode);
      #1;
      if (DoneOut) begin got_k = k; break; end
      if (BusyOut !== 1'b1) bad++;
      if (StallOut !== (ReadHiLoIn | StartIn)) bad++;
      @(negedge Clk);
    end
    check({tag, " latency"}, 64'(got_k), 64'(runc + 1));
    check({tag, " busy/stall"}, 64'(bad), 64'(0));
    if (got_k >= 0) begin
      check({tag, " busy@done"}, 64'(BusyOut), 64'(0));
      check({tag, " stall@done"}, 64'(StallOut), 64'(0));
      check({tag, " hi"}, 64'(HiOut), 64'(eh));
      check({tag, " lo"}, 64'(LoOut), 64'(el));
    end
    last_hi = eh;
    last_lo = el;
    if (!hold) begin
      StartIn = 1'b0; ReadHiLoIn = 1'b0;
      @(negedge Clk); #1;
      check({tag, " done pulse"}, 64'(DoneOut), 64'(0));
    end
  endtask

  logic [1:0]   ops [0:40];
  logic [W-1:0] as  [0:40];
  logic [W-1:0] bs  [0:40];

  initial begin
    int cnt;
    bit hold;
    #1 Rst_n = 1'b0;
    #20;
    check("reset hi", 64'(HiOut), 64'(0));
    check("reset lo", 64'(LoOut), 64'(0));
    check("reset busy", 64'(BusyOut), 64'(0));
    check("reset done", 64'(DoneOut), 64'(0));
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk); #1;

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0, 2'd0, '0, '0, "multu_max");
    run_op(2'd0, 32'hFFFF_FFF9, 32'd6,         1, 1'b0, 2'd0, '0, '0, "mult_neg");
    run_op(2'd2, 32'hFFFF_FFEF, 32'd5,         1, 1'b0, 2'd0, '0, '0, "div_neg");
    run_op(2'd3, 32'd100,       32'd0,         0, 1'b0, 2'd0, '0, '0, "divu_zero");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 2'd0, '0, '0, "div_ovf");
    run_op(2'd2, 32'hFFFF_FFFB, 32'd0,         0, 1'b0, 2'd0, '0, '0, "div_zero_s");
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1, 1'b0, 2'd0, '0, '0, "mult_min");
    run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1, 1'b0, 2'd0, '0, '0, "multu_mix");

    // Cancel during RUN
    StartIn = 1'b1; OpIn = 2'd2; DataAIn = 32'd1000; DataBIn = 32'd7;
    @(negedge Clk);
    StartIn = 1'b0;
    repeat (9) @(negedge Clk);
    CancelIn = 1'b1;
    @(negedge Clk);
    CancelIn = 1'b0; #1;
    check("cancel_run busy", 64'(BusyOut), 64'(0));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin @(negedge Clk); #1; if (DoneOut) cnt++; end
    check("cancel_run done", 64'(cnt), 64'(0));
    check("cancel_run hi", 64'(HiOut), 64'(last_hi));
    check("cancel_run lo", 64'(LoOut), 64'(last_lo));

    // Cancel in FIX
    StartIn = 1'b1; OpIn = 2'd3; DataAIn = 32'd77; DataBIn = 32'd3;
    @(negedge Clk);
    StartIn = 1'b0;
    repeat (W) @(negedge Clk);
    CancelIn = 1'b1; #1;
    check("cancel_fix busy before", 64'(BusyOut), 64'(1));
    @(negedge Clk);
    CancelIn = 1'b0; #1;
    check("cancel_fix done", 64'(DoneOut), 64'(0));
    check("cancel_fix busy", 64'(BusyOut), 64'(0));
    check("cancel_fix hi", 64'(HiOut), 64'(last_hi));
    check("cancel_fix lo", 64'(LoOut), 64'(last_lo));

    // Start together with cancel in IDLE is dropped
    StartIn = 1'b1; CancelIn = 1'b1; OpIn = 2'd1; DataAIn = 32'd5; DataBIn = 32'd5;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin @(negedge Clk); #1; if (BusyOut) cnt++; end
    StartIn = 1'b0; CancelIn = 1'b0;
    check("start_cancel idle", 64'(cnt), 64'(0));

    // Asynchronous reset mid-RUN
    @(negedge Clk);
    StartIn = 1'b1; OpIn = 2'd2; DataAIn = 32'd12345; DataBIn = 32'd17;
    @(negedge Clk);
    StartIn = 1'b0;
    repeat (15) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    check("rst_run hi", 64'(HiOut), 64'(0));
    check("rst_run lo", 64'(LoOut), 64'(0));
    check("rst_run busy", 64'(BusyOut), 64'(0));
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk); #1;
    run_op(2'd2, 32'd12345, 32'd17, 0, 1'b0, 2'd0, '0, '0, "after_rst");

    // Randomized ops, some re-presented back-to-back while stalled
    for (int i = 0; i <= 40; i++) begin
      ops[i] = 2'($urandom_range(0, 3));
      as[i] = rnd_val();
      bs[i] = rnd_val();
    end
    for (int i = 0; i < 40; i++) begin
      hold = (i < 39) && ($urandom_range(0, 3) == 0);
      run_op(ops[i], as[i], bs[i], 1, hold, ops[i+1], as[i+1], bs[i+1], $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
